// File: rtl/image_ram_pkg.sv
// Shared types and default widths for the image RAM controller and the RAM it drives.
package image_ram_pkg;

    localparam int unsigned DEF_D_WIDTH = 8;
    localparam int unsigned DEF_A_WIDTH = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_e;

    // One-hot so the arbiter output can be used directly as per-requester grants.
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_WR   = 2'b01,
        GNT_RD   = 2'b10
    } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: req[0] is the pixel writer, req[1] the pixel reader.
module rr_arb2
    import image_ram_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    output grant_e     grant
);

    // Remembers who won the last contended grant; reset value makes read win first.
    logic lastWasRd_q;
    logic lastWasRd_d;

    always_comb begin
        grant       = GNT_NONE;
        lastWasRd_d = lastWasRd_q;
        if (enable) begin
            unique case (req)
                2'b01:   grant = GNT_WR;
                2'b10:   grant = GNT_RD;
                2'b11: begin
                    grant       = lastWasRd_q ? GNT_WR : GNT_RD;
                    lastWasRd_d = !lastWasRd_q;
                end
                default: grant = GNT_NONE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lastWasRd_q <= 1'b0;
        end else begin
            lastWasRd_q <= lastWasRd_d;
        end
    end

endmodule

// File: rtl/image_ram_ctrl.sv
// Clear sequencer and write/read arbiter for the single-port image RAM.
// Optional clear-after-reset feature is enabled by defining IMAGE_RAM_CLEAR_EN.
module image_ram_ctrl
    import image_ram_pkg::*;
#(
    parameter int unsigned         D_WIDTH     = DEF_D_WIDTH,
    parameter int unsigned         A_WIDTH     = DEF_A_WIDTH,
    parameter logic [D_WIDTH-1:0]  CLEAR_VALUE = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_start,
    output logic               clear_busy,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    input  logic               rd_valid,
    output logic               rd_ready,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic               rd_data_valid,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               ram_wren,
    output logic [A_WIDTH-1:0] ram_address,
    output logic [D_WIDTH-1:0] ram_data,
    input  logic [D_WIDTH-1:0] ram_q
);

    grant_e grant;
    logic   arbEnable;
    logic   clearing;
    logic   rdDataValid_q;

`ifdef IMAGE_RAM_CLEAR_EN
    state_e             state_q;
    state_e             state_d;
    logic [A_WIDTH-1:0] clrCnt_q;
    logic [A_WIDTH-1:0] clrCnt_d;

    // clear_start wins over everything, so a clear can be restarted from any cycle.
    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        if (clear_start) begin
            state_d  = CLEAR;
            clrCnt_d = '0;
        end else if (state_q == CLEAR) begin
            clrCnt_d = clrCnt_q + 1'b1;
            if (&clrCnt_q) begin
                state_d = SERVE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= CLEAR;
            clrCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
        end
    end

    assign clearing  = (state_q == CLEAR);
    assign arbEnable = (state_q == SERVE) && !clear_start && !reset;
`else
    logic unusedClearPath;

    assign unusedClearPath = clear_start ^ (^CLEAR_VALUE);
    assign clearing        = 1'b0;
    assign arbEnable       = !reset;
`endif

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (arbEnable),
        .req    ({rd_valid, wr_valid}),
        .grant  (grant)
    );

    // All RAM-side and handshake outputs are forced low while reset is held.
    always_comb begin
        ram_wren    = 1'b0;
        ram_address = rd_addr;
        ram_data    = wr_data;
        wr_ready    = 1'b0;
        rd_ready    = 1'b0;
        clear_busy  = 1'b0;
        if (reset) begin
            ram_address = '0;
            ram_data    = '0;
        end else if (clearing) begin
`ifdef IMAGE_RAM_CLEAR_EN
            ram_wren    = 1'b1;
            ram_address = clrCnt_q;
            ram_data    = CLEAR_VALUE;
            clear_busy  = 1'b1;
`endif
        end else begin
            unique case (grant)
                GNT_WR: begin
                    ram_wren    = 1'b1;
                    ram_address = wr_addr;
                    wr_ready    = 1'b1;
                end
                GNT_RD:  rd_ready = 1'b1;
                default: ram_wren = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdDataValid_q <= 1'b0;
        end else begin
            rdDataValid_q <= rd_valid && rd_ready;
        end
    end

    assign rd_data_valid = rdDataValid_q && !reset;
    assign rd_data       = ram_q;

endmodule

// File: tb/tb_image_ram_ctrl.sv
// Randomized scoreboard bench for image_ram_ctrl with a small RAM model and a behavioural reference.
module tb_image_ram_ctrl;

    localparam int          AW    = 4;
    localparam int          DW    = 8;
    localparam int          DEPTH = 16;
    localparam logic [7:0]  CV    = 8'hA5;
`ifdef IMAGE_RAM_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear_start = 1'b0;
    logic          wr_valid = 1'b0;
    logic          rd_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clear_busy, wr_ready, rd_ready, rd_data_valid, ram_wren;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] rd_data, ram_data, ram_q;

    image_ram_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .CLEAR_VALUE(CV)) dut (
        .clock         (clock),
        .reset         (reset),
        .clear_start   (clear_start),
        .clear_busy    (clear_busy),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .ram_wren      (ram_wren),
        .ram_address   (ram_address),
        .ram_data      (ram_data),
        .ram_q         (ram_q)
    );

    always #5 clock = ~clock;

    // Single-port RAM with registered read, as it sits next to the controller.
    logic [DW-1:0] ramMem [DEPTH];
    always @(posedge clock) begin
        if (ram_wren) ramMem[ram_address] <= ram_data;
        ram_q <= ramMem[ram_address];
    end

    typedef struct {
        bit         known;
        logic [7:0] data;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monExp;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] modelMem [DEPTH];
    bit         memKnown [DEPTH];
    bit         modelClearing = 1'b0;
    int         modelCnt = 0;
    bit         nextContendedRd = 1'b1;
    bit         expRdValid = 1'b0;
    bit         lastWrAcc = 1'b0;
    bit         lastRdAcc = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read data is compared whenever the DUT flags it valid, against what the model queued.
    always @(negedge clock) begin
        if (!reset && rd_data_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_unexpected: got rd_data_valid=1 expected no pending read at %0t", $time);
            end else begin
                monExp = expQ.pop_front();
                if (monExp.known) checkOutput("rd_data", 32'(rd_data), 32'(monExp.data));
            end
        end
    end

    // One clock: compare outputs at the falling edge against the reference, then advance it.
    task automatic applyStimulus();
        bit expWr;
        bit expRd;
        expWr = 1'b0;
        expRd = 1'b0;
        @(negedge clock);
        checkOutput("rd_data_valid", 32'(rd_data_valid), 32'(expRdValid));
        if (CLEAR_EN && modelClearing) begin
            checkOutput("clear_busy", 32'(clear_busy), 32'd1);
            checkOutput("clear_wren", 32'(ram_wren), 32'd1);
            checkOutput("clear_addr", 32'(ram_address), 32'(modelCnt));
            checkOutput("clear_data", 32'(ram_data), 32'(CV));
            checkOutput("clear_readies", 32'({wr_ready, rd_ready}), 32'd0);
            modelMem[modelCnt] = CV;
            memKnown[modelCnt] = 1'b1;
            if (clear_start)               modelCnt = 0;
            else if (modelCnt == DEPTH-1)  modelClearing = 1'b0;
            else                           modelCnt++;
        end else begin
            checkOutput("clear_busy", 32'(clear_busy), 32'd0);
            if (CLEAR_EN && clear_start) begin
                modelClearing = 1'b1;
                modelCnt      = 0;
            end else if (wr_valid && rd_valid) begin
                expRd           = nextContendedRd;
                expWr           = !nextContendedRd;
                nextContendedRd = !nextContendedRd;
            end else begin
                expWr = wr_valid;
                expRd = rd_valid;
            end
            checkOutput("wr_ready", 32'(wr_ready), 32'(expWr));
            checkOutput("rd_ready", 32'(rd_ready), 32'(expRd));
            checkOutput("ram_wren", 32'(ram_wren), 32'(expWr));
            if (expWr) begin
                checkOutput("wr_address", 32'(ram_address), 32'(wr_addr));
                checkOutput("wr_ram_data", 32'(ram_data), 32'(wr_data));
            end else begin
                checkOutput("idle_address", 32'(ram_address), 32'(rd_addr));
            end
            if (expRd) expQ.push_back('{memKnown[rd_addr], modelMem[rd_addr]});
            if (expWr) begin
                modelMem[wr_addr] = wr_data;
                memKnown[wr_addr] = 1'b1;
            end
        end
        expRdValid = expRd;
        lastWrAcc  = expWr;
        lastRdAcc  = expRd;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        expQ.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            checkOutput("rst_outputs",
                        32'({wr_ready, rd_ready, rd_data_valid, ram_wren, clear_busy}), 32'd0);
            checkOutput("rst_ram_address", 32'(ram_address), 32'd0);
            checkOutput("rst_ram_data", 32'(ram_data), 32'd0);
            @(posedge clock);
            #1;
        end
        reset           = 1'b0;
        modelClearing   = CLEAR_EN;
        modelCnt        = 0;
        nextContendedRd = 1'b1;
        expRdValid      = 1'b0;
        lastWrAcc       = 1'b0;
        lastRdAcc       = 1'b0;
    endtask

    task automatic waitWrite(input string name);
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (lastWrAcc) break;
        end
        if (!lastWrAcc) checkOutput(name, 32'd0, 32'd1);
        wr_valid = 1'b0;
    endtask

    task automatic doRead(input logic [AW-1:0] addr);
        rd_valid = 1'b1;
        rd_addr  = addr;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (lastRdAcc) break;
        end
        if (!lastRdAcc) checkOutput("read_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) memKnown[i] = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 4'd3;
        wr_data  = 8'h11;
        doReset(3);
        waitWrite("first_write_timeout");

        for (int a = 0; a < DEPTH; a++) doRead(4'(a));
        rd_valid = 1'b0;

        wr_valid = 1'b1;
        wr_addr  = 4'd7;
        wr_data  = 8'h3C;
        waitWrite("write7_timeout");
        doRead(4'd7);
        rd_valid = 1'b0;

        wr_valid = 1'b1;
        rd_valid = 1'b1;
        wr_addr  = 4'($urandom);
        wr_data  = 8'($urandom);
        rd_addr  = 4'($urandom);
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            if (lastWrAcc) begin wr_addr = 4'($urandom); wr_data = 8'($urandom); end
            if (lastRdAcc) rd_addr = 4'($urandom);
        end
        rd_valid = 1'b0;

        wr_valid    = 1'b1;
        wr_addr     = 4'd9;
        wr_data     = 8'h5A;
        clear_start = 1'b1;
        applyStimulus();
        clear_start = 1'b0;
        if (!lastWrAcc) waitWrite("write_after_clear_timeout");
        wr_valid = 1'b0;
        doRead(4'd9);
        rd_valid = 1'b0;

        for (int i = 0; i < 300; i++) begin
            clear_start = ($urandom_range(0, 99) == 0);
            if (!wr_valid || lastWrAcc) begin
                wr_valid = 1'($urandom);
                wr_addr  = 4'($urandom);
                wr_data  = 8'($urandom);
            end
            if (!rd_valid || lastRdAcc) begin
                rd_valid = 1'($urandom);
                rd_addr  = 4'($urandom);
            end
            applyStimulus();
        end
        clear_start = 1'b0;
        wr_valid    = 1'b0;
        rd_valid    = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus();

        clear_start = 1'b1;
        applyStimulus();
        clear_start = 1'b0;
        rd_valid    = 1'b1;
        rd_addr     = 4'd2;
        for (int i = 0; i < 4; i++) applyStimulus();
        doReset(2);
        for (int i = 0; i < 24; i++) applyStimulus();
        rd_valid = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_ram_ctrl.md
# image_ram_ctrl

Sequencer and arbiter for the single-port image RAM (1-cycle read latency, registered read address). It clears the whole RAM to a constant after reset or on request. It then shares the single port between one pixel-write requester (e.g. the drawing/capture path) and one pixel-read requester (e.g. the display scanner) with round-robin arbitration. The RAM itself is instantiated next to this block; this block drives all RAM inputs.

## Interface
Parameters:
- D_WIDTH, 8, pixel data width; matches the RAM.
- A_WIDTH, 16, address width; RAM depth is 2**A_WIDTH.
- CLEAR_VALUE, 0, D_WIDTH-bit value written to every location during a clear.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clear_start  in  1  single-cycle pulse requesting a full-RAM clear.
- clear_busy  out  1  high while the clear sequence runs.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  A_WIDTH  write address.
- wr_data  in  D_WIDTH  write data.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted this cycle.
- rd_addr  in  A_WIDTH  read address.
- rd_data_valid  out  1  rd_data holds the result of the read accepted in the previous cycle.
- rd_data  out  D_WIDTH  read data; combinational from ram_q.
- ram_wren  out  1  RAM write enable.
- ram_address  out  A_WIDTH  RAM address.
- ram_data  out  D_WIDTH  RAM write data.
- ram_q  in  D_WIDTH  RAM read data.

## Operation
- States: CLEAR and SERVE. Reset enters CLEAR; clear counter is set to 0.
- CLEAR behaviour:
  - Each cycle: ram_wren=1, ram_address=counter, ram_data=CLEAR_VALUE; counter increments.
  - After address 2**A_WIDTH-1 is written, go to SERVE.
  - wr_ready=rd_ready=0 throughout; clear_busy=1.
- SERVE behaviour:
  - Only wr_valid: grant write. ram_wren=1, ram_address=wr_addr, ram_data=wr_data, wr_ready=1.
  - Only rd_valid: grant read. ram_wren=0, ram_address=rd_addr, rd_ready=1.
  - Both valid: round-robin. Grant the requester not served at the last contended grant. The first contended grant after reset goes to read.
  - No grant: ram_wren=0, ram_address=rd_addr, ram_data=wr_data.
- Handshake rules:
  - wr_ready and rd_ready are combinational from state, the valids and the round-robin flag. At most one is high per cycle.
  - A requester holds valid, address and data stable until ready.
  - A transfer occurs on the cycle where valid and ready are both high.
- clear_start:
  - In SERVE: go to CLEAR with counter=0 on the next cycle. No grant is issued in the cycle clear_start is sampled.
  - In CLEAR: restarts the counter at 0.
- Simultaneous write and read to the same address cannot occur, because only one grant is issued per cycle. A read granted immediately after a write to the same address returns the new data.

## Timing
- While reset is high, all outputs are 0: wr_ready, rd_ready, rd_data_valid, ram_wren, ram_address, ram_data, clear_busy. rd_data follows ram_q.
- The first cycle after reset deasserts is CLEAR cycle 0, with clear_busy=1.
- A clear takes exactly 2**A_WIDTH cycles. clear_busy falls in the cycle SERVE is entered, and grants are possible in that same cycle.
- Write latency: data is stored at the rising edge closing the grant cycle.
- Read latency: 1 cycle. rd_data_valid is a register set by (rd_valid & rd_ready) and cleared otherwise. rd_data is valid only while rd_data_valid=1.
- Back-to-back reads sustain 1 read per cycle.
- Fully contended traffic alternates W/R, giving each requester 50% of cycles.
- Reset mid-clear or mid-read:
  - Restarts the clear.
  - A pending rd_data_valid is dropped (0 next cycle).
  - The round-robin flag returns to read-first.

## Configuration
- IMAGE_RAM_CLEAR_EN defined: CLEAR state and counter are present, with behaviour as above.
- Not defined:
  - Reset enters SERVE directly.
  - clear_start is ignored and clear_busy is tied to 0.
  - The counter and CLEAR_VALUE path are removed.
  - RAM contents after reset are undefined.

## Structure
- Package image_ram_pkg contains:
  - state enum (CLEAR, SERVE);
  - grant enum (GNT_NONE, GNT_WR, GNT_RD);
  - default width constants shared with the RAM.
- Sub-module rr_arb2: two-requester round-robin arbiter.
  - Inputs: req[1:0], enable.
  - Outputs: one-hot grant.
  - Internal last-grant flag, synchronous reset to read-first.
- The top level holds the FSM, clear counter, RAM muxing and the rd_data_valid register.

## Test plan
Bench uses A_WIDTH=4, D_WIDTH=8, CLEAR_VALUE=8'hA5.
- Clear after reset: release reset -> clear_busy=1 for exactly 16 cycles, with ram_wren=1 and addresses 0..15. Reading any address afterwards -> rd_data=8'hA5.
- Write/read back: write 8'h3C to addr 7, then read addr 7 -> rd_data_valid=1 one cycle after rd_ready, rd_data=8'h3C.
- Contention: wr_valid and rd_valid both held high for 6 cycles -> grants R,W,R,W,R,W. No cycle has both readies high.
- clear_start in SERVE: pulse during a pending write -> no grant that cycle, wr_ready=0 for 16 cycles. The write completes after clear_busy falls.
- Reset mid-clear at cycle 5: counter restarts, a full 16-cycle clear follows, and rd_data_valid stays 0.
- Macro off: reset -> clear_busy=0, and wr_ready=1 on the first cycle after reset with wr_valid=1.
